// File: rtl/prm_edge_chk_sched.sv
// Round-robin sequencer for the shared PRM obstacle checker: walks one sample
// code per cycle per granted sweep and reports the first masked sample.
module prm_edge_chk_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CODE_W  = 15,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned STRIDE  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [CODE_W-1:0]         chk_code,
  output logic                      chk_en,
  input  logic                      chk_mask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_blocked,
  output logic [LEN_W-1:0]          rsp_idx,
  output logic                      busy,
  output logic [31:0]               chk_count
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic              win_vld;
  logic [CODE_W-1:0] win_code;
  logic [LEN_W-1:0]  win_len;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k;
  logic              last;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_vld && req_valid[ID_W'((32'(ptr) + j) % NUM_REQ)]) begin
        win_vld = 1'b1;
        win     = ID_W'((32'(ptr) + j) % NUM_REQ);
      end
    end
  end

  assign win_code = req_code[32'(win)*CODE_W +: CODE_W];
  assign win_len  = req_len[32'(win)*LEN_W +: LEN_W];
  assign last     = (k == len_q - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          req_ready[win] = 1'b1;
          state_nxt      = (win_len == '0) ? RESP : RUN;
        end
      end
      RUN:     if (chk_mask || last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign chk_en    = (state == RUN);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ptr         <= '0;
      len_q       <= '0;
      k           <= '0;
      chk_code    <= '0;
      rsp_id      <= '0;
      rsp_blocked <= 1'b0;
      rsp_idx     <= '0;
      chk_count   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_vld) begin
            rsp_id      <= win;
            ptr         <= ID_W'((32'(win) + 1) % NUM_REQ);
            len_q       <= win_len;
            k           <= '0;
            rsp_blocked <= 1'b0;
            rsp_idx     <= '0;
            // A zero-length sweep never drives the checker, so chk_code keeps its old value.
            if (win_len != '0) chk_code <= win_code;
          end
        end
        RUN: begin
          if (chk_count != '1) chk_count <= chk_count + 32'd1;
          if (chk_mask) begin
            rsp_blocked <= 1'b1;
            rsp_idx     <= k;
          end else if (last) begin
            rsp_blocked <= 1'b0;
            rsp_idx     <= '0;
          end else begin
            k        <= k + LEN_W'(1);
            chk_code <= chk_code + CODE_W'(STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
